// File: rtl/op_stack_if.sv
// op_stack_if: operation request, spill-memory and error signals of op_stack
interface op_stack_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int MEM_ENTRIES = 16,
  parameter int ADDR_WIDTH = 10
);
  localparam int CW = $clog2(DEPTH + MEM_ENTRIES + 1);
  logic                  op_valid, op_ready, clear_err;
  logic [2:0]            op;
  logic [WIDTH-1:0]      op_data, top0, top1;
  logic [CW-1:0]         count;
  logic                  mem_req, mem_we, mem_ack;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0]      mem_wdata, mem_rdata;
  logic                  err_overflow, err_underflow;
  modport master (
    output op_valid, op, op_data, mem_rdata, mem_ack, clear_err,
    input  op_ready, top0, top1, count, mem_req, mem_we, mem_addr, mem_wdata, err_overflow, err_underflow
  );
  modport slave (
    input  op_valid, op, op_data, mem_rdata, mem_ack, clear_err,
    output op_ready, top0, top1, count, mem_req, mem_we, mem_addr, mem_wdata, err_overflow, err_underflow
  );
endinterface

// File: rtl/op_stack.sv
// op_stack: operand stack with DEPTH register entries that spills its bottom
// entries to memory when full and refills them on demand.
module op_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int MEM_ENTRIES = 16,
  parameter int ADDR_WIDTH = 10,
  parameter logic [ADDR_WIDTH-1:0] SPILL_BASE = 10'h020,
  parameter int STRIDE = 2
) (
  input logic clk,
  input logic rst_n,
  op_stack_if.slave bus
);
  localparam int CW = $clog2(DEPTH + MEM_ENTRIES + 1);
  localparam int RW = $clog2(DEPTH);
  localparam logic [CW-1:0] D = CW'(DEPTH);
  localparam logic [CW-1:0] M = CW'(MEM_ENTRIES);
  localparam logic [ADDR_WIDTH-1:0] ST = ADDR_WIDTH'(STRIDE);
  typedef enum logic [1:0] {IDLE, SPILL, FILL} state_t;
  state_t                state_q;
  logic [WIDTH-1:0]      stk_q [DEPTH];
  logic [WIDTH-1:0]      stk_d [DEPTH];
  logic [CW-1:0]         rc_q, mc_q, rc_d, need;
  logic                  mem_req_q, mem_we_q, uf_q, of_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [WIDTH-1:0]      mem_wdata_q;
  logic                  grows, spill_go, fill_go, uf, of;
  always_comb begin
    need = bus.op inside {3'd2, 3'd3} ? CW'(1) :
           bus.op inside {3'd4, 3'd6, 3'd7} ? CW'(2) :
           bus.op == 3'd5 ? CW'(bus.op_data[0]) + CW'(1) : '0;
    grows = bus.op == 3'd1 || bus.op == 3'd5;
    spill_go = grows && rc_q == D && mc_q < M;
    fill_go = rc_q < need && mc_q != '0;
    uf = rc_q + mc_q < need;
    of = grows && rc_q == D && mc_q == M;
    rc_d = grows ? rc_q + 1'b1 :
           bus.op inside {3'd2, 3'd4} ? rc_q - 1'b1 :
           bus.op == 3'd7 ? rc_q - CW'(2) : rc_q;
    stk_d = stk_q;
    case (bus.op)
      3'd1, 3'd5: begin
        for (int i = DEPTH - 1; i > 0; i--) stk_d[i] = stk_q[i-1];
        stk_d[0] = bus.op == 3'd1 ? bus.op_data : bus.op_data[0] ? stk_q[1] : stk_q[0];
      end
      3'd2, 3'd4: begin
        for (int i = 0; i < DEPTH - 1; i++) stk_d[i] = stk_q[i+1];
        stk_d[DEPTH-1] = '0;
        if (bus.op == 3'd4) stk_d[0] = bus.op_data;
      end
      3'd3: stk_d[0] = bus.op_data;
      3'd6: begin
        stk_d[0] = stk_q[1];
        stk_d[1] = stk_q[0];
      end
      3'd7: begin
        for (int i = 0; i < DEPTH - 2; i++) stk_d[i] = stk_q[i+2];
        stk_d[DEPTH-2] = '0;
        stk_d[DEPTH-1] = '0;
      end
      default: ;
    endcase
  end
  assign bus.op_ready      = state_q == IDLE && !spill_go && !fill_go;
  assign bus.top0          = stk_q[0];
  assign bus.top1          = stk_q[1];
  assign bus.count         = rc_q + mc_q;
  assign bus.mem_req       = mem_req_q;
  assign bus.mem_we        = mem_we_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.err_overflow  = of_q;
  assign bus.err_underflow = uf_q;
  // error sets are written after the clear so they win in the same cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rc_q <= '0;
      mc_q <= '0;
      mem_req_q <= 1'b0;
      mem_we_q <= 1'b0;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
      uf_q <= 1'b0;
      of_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) stk_q[i] <= '0;
    end else begin
      if (bus.clear_err) begin
        uf_q <= 1'b0;
        of_q <= 1'b0;
      end
      case (state_q)
        IDLE: if (bus.op_valid) begin
          if (spill_go) begin
            state_q <= SPILL;
            mem_req_q <= 1'b1;
            mem_we_q <= 1'b1;
            mem_addr_q <= SPILL_BASE + ADDR_WIDTH'(mc_q) * ST;
            mem_wdata_q <= stk_q[DEPTH-1];
          end else if (fill_go) begin
            state_q <= FILL;
            mem_req_q <= 1'b1;
            mem_we_q <= 1'b0;
            mem_addr_q <= SPILL_BASE + ADDR_WIDTH'(mc_q - 1'b1) * ST;
          end else if (uf) uf_q <= 1'b1;
          else if (of) of_q <= 1'b1;
          else begin
            stk_q <= stk_d;
            rc_q <= rc_d;
          end
        end
        default: if (bus.mem_ack) begin
          state_q <= IDLE;
          mem_req_q <= 1'b0;
          mem_we_q <= 1'b0;
          if (state_q == SPILL) begin
            stk_q[DEPTH-1] <= '0;
            rc_q <= rc_q - 1'b1;
            mc_q <= mc_q + 1'b1;
          end else begin
            stk_q[rc_q[RW-1:0]] <= bus.mem_rdata;
            rc_q <= rc_q + 1'b1;
            mc_q <= mc_q - 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_op_stack.sv
// tb_op_stack: directed scenarios plus randomized op sequences checked against
// a queue-based model of the logical stack and its register residency.
module tb_op_stack;
  localparam int W = 16, D = 4, M = 4, AW = 10;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  op_stack_if #(.WIDTH(W), .DEPTH(D), .MEM_ENTRIES(M), .ADDR_WIDTH(AW)) bus ();
  op_stack #(.WIDTH(W), .DEPTH(D), .MEM_ENTRIES(M), .ADDR_WIDTH(AW),
             .SPILL_BASE(10'h020), .STRIDE(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int checks = 0, errors = 0;
  // memory responder: acks one cycle after a request appears
  logic ack_en = 1'b1, ack_r = 1'b0, force_ack = 1'b0;
  logic [W-1:0] rdata_r = '0, last_wd = '0;
  logic [AW-1:0] last_wa = '0, last_ra = '0;
  logic [W-1:0] mem [1024];
  int wr_cnt = 0, rd_cnt = 0;
  assign bus.mem_ack = ack_r | force_ack;
  assign bus.mem_rdata = rdata_r;
  always @(negedge clk) begin
    ack_r <= ack_en && bus.mem_req && !ack_r;
    if (ack_en && bus.mem_req && !ack_r) begin
      if (bus.mem_we) begin
        mem[bus.mem_addr] <= bus.mem_wdata;
        wr_cnt <= wr_cnt + 1;
        last_wa <= bus.mem_addr;
        last_wd <= bus.mem_wdata;
      end else begin
        rdata_r <= mem[bus.mem_addr];
        rd_cnt <= rd_cnt + 1;
        last_ra <= bus.mem_addr;
      end
    end
  end
  // reference model: mq[0] is the logical top, mrc how many sit in registers
  logic [W-1:0] mq [$];
  int mrc = 0, m_wr = 0, m_rd = 0;
  bit m_uf = 0, m_of = 0;
  function automatic void model_apply(input logic [2:0] op, input logic [W-1:0] d, input bit clr);
    int need = (op == 2 || op == 3) ? 1 : (op == 4 || op == 6 || op == 7) ? 2 : (op == 5) ? 1 + int'(d[0]) : 0;
    bit grows = (op == 1 || op == 5);
    logic [W-1:0] t;
    while (grows && mrc == D && mq.size() - mrc < M) begin mrc--; m_wr++; end
    while (mrc < need && mq.size() - mrc > 0) begin mrc++; m_rd++; end
    if (clr) begin m_uf = 0; m_of = 0; end
    if (mq.size() < need) m_uf = 1;
    else if (grows && mrc == D && mq.size() == D + M) m_of = 1;
    else case (op)
      3'd1: begin mq.push_front(d); mrc++; end
      3'd2: begin void'(mq.pop_front()); mrc--; end
      3'd3: mq[0] = d;
      3'd4: begin void'(mq.pop_front()); mq[0] = d; mrc--; end
      3'd5: begin t = mq[d[0]]; mq.push_front(t); mrc++; end
      3'd6: begin t = mq[0]; mq[0] = mq[1]; mq[1] = t; end
      3'd7: begin void'(mq.pop_front()); void'(mq.pop_front()); mrc -= 2; end
      default: ;
    endcase
  endfunction
  task automatic do_op(input logic [2:0] op, input logic [W-1:0] d, input bit clr, output int stall);
    bit acc = 0;
    stall = 0;
    bus.op_valid = 1'b1; bus.op = op; bus.op_data = d; bus.clear_err = clr;
    #1;
    for (int i = 0; i < 40; i++) begin
      if (bus.op_ready) begin acc = 1; break; end
      stall++;
      @(negedge clk); #1;
    end
    @(negedge clk); #1;
    bus.op_valid = 1'b0; bus.clear_err = 1'b0;
    checks++;
    if (!acc) begin errors++; $display("FAIL accept op=%0d got ready=0 want ready=1 within 40 cycles", op); end
    else model_apply(op, d, clr);
  endtask
  task automatic do_reset();
    bus.op_valid = 1'b0; bus.clear_err = 1'b0;
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    rst_n = 1'b1;
    mq.delete(); mrc = 0; m_uf = 0; m_of = 0;
  endtask
  task automatic pulse_clear();
    bus.clear_err = 1'b1;
    @(negedge clk); #1;
    bus.clear_err = 1'b0;
    m_uf = 0; m_of = 0;
  endtask
  task automatic test_reset();
    do_reset();
    checks += 5;
    if (bus.count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.count); end
    if (bus.top0 !== 16'd0) begin errors++; $display("FAIL reset_top0 got %0h want 0", bus.top0); end
    if (bus.top1 !== 16'd0) begin errors++; $display("FAIL reset_top1 got %0h want 0", bus.top1); end
    if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b want 0", bus.mem_req); end
    if ({bus.err_overflow, bus.err_underflow} !== 2'b00) begin errors++; $display("FAIL reset_err got %b want 00", {bus.err_overflow, bus.err_underflow}); end
  endtask
  task automatic test_push3();
    int st, base = wr_cnt + rd_cnt;
    for (int i = 1; i <= 3; i++) do_op(3'd1, 16'(i), 0, st);
    checks += 4;
    if (bus.top0 !== 16'd3) begin errors++; $display("FAIL push3_top0 got %0h want 3", bus.top0); end
    if (bus.top1 !== 16'd2) begin errors++; $display("FAIL push3_top1 got %0h want 2", bus.top1); end
    if (bus.count !== 4'd3) begin errors++; $display("FAIL push3_count got %0d want 3", bus.count); end
    if (wr_cnt + rd_cnt !== base) begin errors++; $display("FAIL push3_mem got %0d transfers want 0", wr_cnt + rd_cnt - base); end
  endtask
  task automatic test_spill();
    int st;
    do_op(3'd1, 16'd4, 0, st);
    do_op(3'd1, 16'd5, 0, st);
    checks += 5;
    if (st == 0) begin errors++; $display("FAIL spill_stall got %0d stall cycles want >0", st); end
    if (last_wa !== 10'h020 || last_wd !== 16'd1) begin errors++; $display("FAIL spill_write got %0h@%0h want 1@20", last_wd, last_wa); end
    if (bus.top0 !== 16'd5) begin errors++; $display("FAIL spill_top0 got %0h want 5", bus.top0); end
    if (bus.top1 !== 16'd4) begin errors++; $display("FAIL spill_top1 got %0h want 4", bus.top1); end
    if (bus.count !== 4'd5) begin errors++; $display("FAIL spill_count got %0d want 5", bus.count); end
  endtask
  task automatic test_fill_swap();
    int st;
    for (int i = 0; i < 3; i++) do_op(3'd2, 16'd0, 0, st);
    do_op(3'd6, 16'd0, 0, st);
    checks += 5;
    if (st == 0 || last_ra !== 10'h020) begin errors++; $display("FAIL fill_read got stall=%0d addr=%0h want stall>0 addr=20", st, last_ra); end
    if (bus.top0 !== 16'd1) begin errors++; $display("FAIL swap_top0 got %0h want 1", bus.top0); end
    if (bus.top1 !== 16'd2) begin errors++; $display("FAIL swap_top1 got %0h want 2", bus.top1); end
    if (bus.count !== 4'd2) begin errors++; $display("FAIL swap_count got %0d want 2", bus.count); end
    if (bus.err_underflow !== 1'b0) begin errors++; $display("FAIL swap_uf got %b want 0", bus.err_underflow); end
  endtask
  task automatic test_underflow();
    int st;
    do_reset();
    do_op(3'd4, 16'h55, 0, st);
    checks += 2;
    if (bus.err_underflow !== 1'b1) begin errors++; $display("FAIL uf_set got %b want 1", bus.err_underflow); end
    if (bus.count !== 4'd0) begin errors++; $display("FAIL uf_count got %0d want 0", bus.count); end
    pulse_clear();
    checks++;
    if (bus.err_underflow !== 1'b0) begin errors++; $display("FAIL uf_clear got %b want 0", bus.err_underflow); end
    do_op(3'd4, 16'h55, 1, st);
    checks++;
    if (bus.err_underflow !== 1'b1) begin errors++; $display("FAIL uf_priority got %b want 1", bus.err_underflow); end
  endtask
  task automatic test_overflow();
    int st, base;
    do_reset();
    base = wr_cnt;
    for (int i = 1; i <= 9; i++) do_op(3'd1, 16'(i), 0, st);
    checks += 6;
    if (bus.err_overflow !== 1'b1) begin errors++; $display("FAIL of_set got %b want 1", bus.err_overflow); end
    if (bus.count !== 4'd8) begin errors++; $display("FAIL of_count got %0d want 8", bus.count); end
    if (bus.top0 !== 16'd8) begin errors++; $display("FAIL of_top0 got %0h want 8", bus.top0); end
    if (bus.top1 !== 16'd7) begin errors++; $display("FAIL of_top1 got %0h want 7", bus.top1); end
    if (wr_cnt - base !== 4) begin errors++; $display("FAIL of_spills got %0d want 4", wr_cnt - base); end
    if (last_wa !== 10'h026 || last_wd !== 16'd4) begin errors++; $display("FAIL of_last_spill got %0h@%0h want 4@26", last_wd, last_wa); end
  endtask
  task automatic test_reset_mid();
    int st;
    bit seen = 0;
    do_reset();
    for (int i = 1; i <= 4; i++) do_op(3'd1, 16'(i), 0, st);
    ack_en = 1'b0;
    bus.op_valid = 1'b1; bus.op = 3'd1; bus.op_data = 16'd5;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (bus.mem_req) begin seen = 1; break; end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL mid_req got mem_req=0 want 1 within 10 cycles"); end
    rst_n = 1'b0;
    @(negedge clk); #1;
    checks += 3;
    if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL mid_rst_req got %b want 0", bus.mem_req); end
    if (bus.count !== 4'd0) begin errors++; $display("FAIL mid_rst_count got %0d want 0", bus.count); end
    if (bus.top0 !== 16'd0) begin errors++; $display("FAIL mid_rst_top0 got %0h want 0", bus.top0); end
    rst_n = 1'b1; bus.op_valid = 1'b0; force_ack = 1'b1;
    @(negedge clk); #1;
    force_ack = 1'b0;
    @(negedge clk); #1;
    checks += 3;
    if (bus.count !== 4'd0) begin errors++; $display("FAIL late_ack_count got %0d want 0", bus.count); end
    if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL late_ack_req got %b want 0", bus.mem_req); end
    if (bus.op_ready !== 1'b1) begin errors++; $display("FAIL late_ack_ready got %b want 1", bus.op_ready); end
    ack_en = 1'b1;
    mq.delete(); mrc = 0; m_uf = 0; m_of = 0;
  endtask
  task automatic test_random();
    int st, r, bw, br, mw0, mr0;
    logic [2:0] op;
    logic [W-1:0] d, e0, e1;
    do_reset();
    bw = wr_cnt; br = rd_cnt; mw0 = m_wr; mr0 = m_rd;
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 99);
      op = r < 35 ? 3'd1 : r < 45 ? 3'd5 : r < 62 ? 3'd2 : r < 70 ? 3'd3 : r < 78 ? 3'd4 : r < 86 ? 3'd6 : r < 93 ? 3'd7 : 3'd0;
      d = 16'($urandom);
      do_op(op, d, $urandom_range(0, 15) == 0, st);
      e0 = mrc >= 1 ? mq[0] : '0;
      e1 = mrc >= 2 ? mq[1] : '0;
      checks += 5;
      if (bus.top0 !== e0) begin errors++; $display("FAIL rnd_top0 n=%0d op=%0d got %0h want %0h", n, op, bus.top0, e0); end
      if (bus.top1 !== e1) begin errors++; $display("FAIL rnd_top1 n=%0d op=%0d got %0h want %0h", n, op, bus.top1, e1); end
      if (int'(bus.count) !== mq.size()) begin errors++; $display("FAIL rnd_count n=%0d op=%0d got %0d want %0d", n, op, bus.count, mq.size()); end
      if (bus.err_underflow !== m_uf) begin errors++; $display("FAIL rnd_uf n=%0d op=%0d got %b want %b", n, op, bus.err_underflow, m_uf); end
      if (bus.err_overflow !== m_of) begin errors++; $display("FAIL rnd_of n=%0d op=%0d got %b want %b", n, op, bus.err_overflow, m_of); end
    end
    checks += 2;
    if (wr_cnt - bw !== m_wr - mw0) begin errors++; $display("FAIL rnd_spills got %0d want %0d", wr_cnt - bw, m_wr - mw0); end
    if (rd_cnt - br !== m_rd - mr0) begin errors++; $display("FAIL rnd_fills got %0d want %0d", rd_cnt - br, m_rd - mr0); end
  endtask
  initial begin
    bus.op_valid = 1'b0; bus.op = 3'd0; bus.op_data = '0; bus.clear_err = 1'b0;
    test_reset();
    test_push3();
    test_spill();
    test_fill_swap();
    test_underflow();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end
endmodule
